// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver-side signal bundle for uart_rx.
//   rx          serial line into the receiver (idle high)
//   data        last good byte
//   valid       one-cycle strobe when data updates
//   framing_err one-cycle strobe when the stop bit samples low
//   busy        receiver is inside a frame
// modport slave is the receiver; modport master is the line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       busy;

  modport master (output rx, input data, valid, framing_err, busy);
  modport slave  (input rx, output data, valid, framing_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  uart_rx_if.slave: rx in; data/valid/framing_err/busy out
// Start edge is qualified at half a bit, then every bit is sampled one full
// bit period later, which lands each sample near the middle of its bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 234
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);
  localparam int          HALF     = CLKS_PER_BIT / 2;
  localparam logic [15:0] HALF_END = 16'(HALF - 1);
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        rx_m, rx_s;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        cnt_done;
  logic        take, bad;

  // START waits half a bit; every other counting state waits a full bit.
  assign cnt_done = (state == START) ? (cnt == HALF_END) : (cnt == BIT_END);

  // state register + datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m            <= 1'b1;
      rx_s            <= 1'b1;
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      shreg           <= '0;
      bus.data        <= '0;
      bus.valid       <= 1'b0;
      bus.framing_err <= 1'b0;
    end else begin
      rx_m            <= bus.rx;
      rx_s            <= rx_m;
      state           <= state_nxt;
      bus.valid       <= take;
      bus.framing_err <= bad;
      if (take) bus.data <= shreg;
      case (state)
        START, STOP: cnt <= cnt_done ? '0 : cnt + 16'd1;
        DATA: begin
          if (cnt_done) begin
            shreg[idx] <= rx_s;
            cnt        <= '0;
            idx        <= idx + 3'd1;   // wraps 7 -> 0 on the way to STOP
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          cnt <= '0;
          idx <= '0;
        end
      endcase
    end
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (cnt_done) state_nxt = rx_s ? IDLE : DATA;   // high at mid-start = glitch
      DATA:    if (cnt_done && idx == 3'd7) state_nxt = STOP;
      STOP:    if (cnt_done) state_nxt = rx_s ? IDLE : RECOVER;
      RECOVER: if (rx_s) state_nxt = IDLE;                     // hold off while line is in break
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    take     = 1'b0;
    bad      = 1'b0;
    if (state == STOP && cnt_done) begin
      take = rx_s;
      bad  = ~rx_s;
    end
    bus.busy = (state != IDLE);
  end
endmodule
